// File: rtl/result_writeback_pkg.sv
// Shared types and sizing helpers for the result write-back stage and its
// sub-blocks.
package result_writeback_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

    localparam int DEF_N = 8;
    localparam int DEF_M = 10;
    localparam int TOTAL = DEF_N * DEF_M;

    // Counter width able to hold 0..total inclusive.
    function automatic int cnt_width(input int total);
        return $clog2(total + 1);
    endfunction

endpackage

// File: rtl/result_writeback_sat_narrow.sv
// Combinational signed narrowing from IN_WIDTH to OUT_WIDTH with clamping to
// the representable range; clamped flags any out-of-range input.
module sat_narrow #(
    parameter int IN_WIDTH  = 33,
    parameter int OUT_WIDTH = 16
) (
    input  logic [IN_WIDTH-1:0]  din,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 clamped
);

    // The value fits exactly when every bit from the output sign bit upward
    // is a copy of the input sign.
    logic [IN_WIDTH-OUT_WIDTH:0] top_bits;
    logic                        fits;

    assign top_bits = din[IN_WIDTH-1:OUT_WIDTH-1];
    assign fits     = (top_bits == '0) || (top_bits == '1);

    always_comb begin
        clamped = ~fits;
        dout    = din[OUT_WIDTH-1:0];
        if (!fits) begin
            if (din[IN_WIDTH-1]) begin
                dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            end else begin
                dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/result_writeback.sv
// Drains matrix-multiplier results from a show-ahead FIFO, saturates them to
// OUT_WIDTH and writes them row-major to result memory, one job of N*M words.
module result_writeback
    import result_writeback_pkg::*;
#(
    parameter int                    N           = DEF_N,
    parameter int                    M           = DEF_M,
    parameter int                    ACCUM_WIDTH = 33,
    parameter int                    OUT_WIDTH   = 16,
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ACCUM_WIDTH-1:0] fifo_head,
    input  logic                   fifo_empty,
    output logic                   pop_fifo,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [OUT_WIDTH-1:0]   wr_data,
    output logic                   sat_flag,
    output logic                   done,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int            JOB_TOTAL = N * M;
    localparam int            CW        = cnt_width(JOB_TOTAL);
    localparam logic [CW-1:0] TOTAL_C   = CW'(JOB_TOTAL);
    localparam logic [CW-1:0] LAST_IDX  = CW'(JOB_TOTAL - 1);

    wb_state_t state, state_next;

    logic [CW-1:0]         cnt;
    logic [CW-1:0]         loaded;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [OUT_WIDTH-1:0]  sat_data;
    logic                  sat_clamp;
    logic                  start_ok;
    logic                  accept;
    logic                  last_accept;

    sat_narrow #(
        .IN_WIDTH (ACCUM_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_sat (
        .din    (fifo_head),
        .dout   (sat_data),
        .clamped(sat_clamp)
    );

    // Write handshake: a word transfers on every rising edge where wr_valid
    // and wr_ready are both high; while wr_valid is high and wr_ready low,
    // wr_addr and wr_data hold their values.
    assign accept      = wr_valid & wr_ready;
    assign last_accept = accept & (cnt == LAST_IDX);
    assign pop_fifo    = (state == RUN) & ~fifo_empty & (~wr_valid | wr_ready)
                         & (loaded < TOTAL_C);

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    start_ok   = 1'b1;
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    start_ok   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Holding register: a pop always refills it, so accept-and-pop in one
    // cycle replaces the old word without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            loaded    <= '0;
            next_addr <= BASE_ADDR;
            wr_addr   <= BASE_ADDR;
            wr_data   <= '0;
            wr_valid  <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (start_ok) begin
            cnt       <= '0;
            loaded    <= '0;
            next_addr <= BASE_ADDR;
            wr_valid  <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= cnt + CW'(1);
            end
            if (pop_fifo) begin
                wr_data   <= sat_data;
                wr_addr   <= next_addr;
                next_addr <= next_addr + ADDR_WIDTH'(1);
                loaded    <= loaded + CW'(1);
                wr_valid  <= 1'b1;
                if (sat_clamp) begin
                    sat_flag <= 1'b1;
                end
            end else if (accept) begin
                wr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Directed and randomized bench for result_writeback with a small N x M job,
// a queue-based FIFO and a behavioural model of the write stream.
module tb_result_writeback;

    localparam int              N     = 2;
    localparam int              M     = 3;
    localparam int              TOTAL = N * M;
    localparam int              AW    = 33;
    localparam int              OW    = 16;
    localparam int              ADW   = 16;
    localparam logic [ADW-1:0]  BASE  = 16'h0100;

    logic           clk;
    logic           rst;
    logic           start;
    logic [AW-1:0]  fifo_head;
    logic           fifo_empty;
    logic           pop_fifo;
    logic           wr_valid;
    logic           wr_ready;
    logic [ADW-1:0] wr_addr;
    logic [OW-1:0]  wr_data;
    logic           sat_flag;
    logic           done;
    logic           busy;
    logic [1:0]     dbg_state;

    result_writeback #(
        .N(N), .M(M), .ACCUM_WIDTH(AW), .OUT_WIDTH(OW),
        .ADDR_WIDTH(ADW), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .fifo_head(fifo_head), .fifo_empty(fifo_empty), .pop_fifo(pop_fifo),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .sat_flag(sat_flag), .done(done), .busy(busy),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO contents and behavioural model of the stage
    logic [AW-1:0]  fifo_q[$];
    logic [ADW+OW-1:0] exp_q[$];
    bit             m_busy, m_done, m_sat, m_valid;
    logic [ADW-1:0] m_addr;
    logic [OW-1:0]  m_data;
    int             pop_job, acc_job, dut_pops;
    int             vectors, miscompares;

    function automatic logic [OW-1:0] sat_ref(input logic [AW-1:0] v);
        longint sv   = longint'($signed(v));
        longint maxv = (longint'(1) <<< (OW - 1)) - 1;
        longint minv = -maxv - 1;
        logic [63:0] tmp;
        if (sv > maxv) return {1'b0, {(OW-1){1'b1}}};
        if (sv < minv) return {1'b1, {(OW-1){1'b0}}};
        tmp = 64'(sv);
        return tmp[OW-1:0];
    endfunction

    function automatic bit clamps(input logic [AW-1:0] v);
        longint sv   = longint'($signed(v));
        longint maxv = (longint'(1) <<< (OW - 1)) - 1;
        return (sv > maxv) || (sv < -maxv - 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_head  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [AW-1:0] v);
        fifo_q.push_back(v);
        refresh_fifo();
    endtask

    function automatic logic [AW-1:0] rand_val();
        logic [AW-1:0] v;
        case ($urandom_range(0, 3))
            0: v = AW'($signed(32'($urandom_range(0, 65535)) - 32'sd32768));
            1: v = AW'($urandom_range(32768, 2000000));
            2: v = AW'(-$signed(32'($urandom_range(32769, 2000000))));
            default: v = {1'($urandom_range(0, 1)), 32'($urandom())};
        endcase
        return v;
    endfunction

    // One clock: check pre-edge outputs at the falling edge, then advance the
    // model on the rising edge and check the registered outputs just after.
    task automatic cycle();
        bit exp_pop, s_acc, s_start;
        logic [AW-1:0] head;
        @(negedge clk);
        exp_pop = m_busy && (fifo_q.size() > 0) && (pop_job < TOTAL) && (!m_valid || wr_ready);
        check("pop_fifo", 64'(pop_fifo), 64'(exp_pop));
        check("wr_valid", 64'(wr_valid), 64'(m_valid));
        if (m_valid) begin
            check("wr_addr", 64'(wr_addr), 64'(m_addr));
            check("wr_data", 64'(wr_data), 64'(m_data));
        end
        if (pop_fifo === 1'b1) dut_pops++;
        s_acc   = m_valid && wr_ready;
        s_start = start;
        @(posedge clk);
        #1;
        if (s_start && !m_busy) begin
            m_busy = 1; m_done = 0; m_sat = 0; pop_job = 0; acc_job = 0; dut_pops = 0;
        end else if (m_busy) begin
            if (s_acc) begin
                exp_q.push_back({m_addr, m_data});
                acc_job++;
                if (!exp_pop) m_valid = 0;
                if (acc_job == TOTAL) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
            if (exp_pop) begin
                head    = fifo_q.pop_front();
                m_data  = sat_ref(head);
                m_addr  = ADW'(32'(BASE) + pop_job);
                m_valid = 1;
                if (clamps(head)) m_sat = 1;
                pop_job++;
            end
        end
        refresh_fifo();
        check("done", 64'(done), 64'(m_done));
        check("busy", 64'(busy), 64'(m_busy));
        check("sat_flag", 64'(sat_flag), 64'(m_sat));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pop"}, 64'(pop_fifo), 64'd0);
        check({tag, "_valid"}, 64'(wr_valid), 64'd0);
        check({tag, "_addr"}, 64'(wr_addr), 64'(BASE));
        check({tag, "_data"}, 64'(wr_data), 64'd0);
        check({tag, "_sat"}, 64'(sat_flag), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic kick();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget, input bit rand_mode);
        int k = 0;
        while (!m_done && k < budget) begin
            if (rand_mode) begin
                wr_ready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) < 6) push(rand_val());
            end
            cycle();
            k++;
        end
        wr_ready = 1'b1;
        check("job_done", 64'(done), 64'd1);
        check("job_pops", 64'(dut_pops), 64'(TOTAL));
    endtask

    initial begin
        int k;
        logic [ADW+OW-1:0] w;
        vectors = 0; miscompares = 0;
        m_busy = 0; m_done = 0; m_sat = 0; m_valid = 0;
        m_addr = BASE; m_data = '0; pop_job = 0; acc_job = 0; dut_pops = 0;
        rst = 1'b1; start = 1'b0; wr_ready = 1'b0;
        refresh_fifo();
        #1;
        check_reset_values("reset");
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // 1..6 at full rate: done exactly 7 edges after the start edge
        for (int i = 1; i <= 6; i++) push(AW'(i));
        wr_ready = 1'b1;
        kick();
        repeat (6) cycle();
        check("t1_done_early", 64'(done), 64'd0);
        cycle();
        check("t1_done", 64'(done), 64'd1);
        check("t1_pops", 64'(dut_pops), 64'd6);
        check("t1_fifo_left", 64'(fifo_q.size()), 64'd0);
        check("t1_writes", 64'(exp_q.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            w = exp_q.pop_front();
            check("t1_stream", 64'(w), 64'({ADW'(32'(BASE) + i), OW'(i + 1)}));
        end

        // back-pressure while element 2 is held
        for (int i = 1; i <= 6; i++) push(AW'(10 * i));
        kick();
        k = 0;
        while (!(m_valid && m_addr == BASE + 16'd2) && k < 20) begin cycle(); k++; end
        check("t2_reach_elem2", 64'(m_addr), 64'(BASE + 16'd2));
        wr_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("t2_hold_addr", 64'(wr_addr), 64'(BASE + 16'd2));
            check("t2_hold_data", 64'(wr_data), 64'd30);
        end
        wr_ready = 1'b1;
        run_to_done(30, 0);

        // saturation corners; a fresh start clears sat_flag
        push(AW'(40000)); push(AW'(-40000)); push(AW'(-32768)); push(AW'(32767));
        push(AW'(5)); push(AW'(-7));
        kick();
        cycle();
        check("t3_first_word", 64'(wr_data), 64'h7FFF);
        check("t3_sat_set", 64'(sat_flag), 64'd1);
        run_to_done(30, 0);
        for (int i = 1; i <= 6; i++) push(AW'(i));
        kick();
        check("t3_sat_cleared", 64'(sat_flag), 64'd0);
        run_to_done(30, 0);

        // FIFO runs dry mid-job, then resumes
        for (int i = 0; i < 3; i++) push(rand_val());
        kick();
        repeat (9) cycle();
        check("t4_drained_valid", 64'(wr_valid), 64'd0);
        check("t4_drained_pops", 64'(dut_pops), 64'd3);
        for (int i = 0; i < 3; i++) push(rand_val());
        cycle();
        check("t4_resume_addr", 64'(wr_addr), 64'(BASE + 16'd3));
        run_to_done(30, 0);

        // surplus entries, start while running, restart from DONE
        for (int i = 0; i < 8; i++) push(rand_val());
        kick();
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        run_to_done(100, 0);
        check("t5_left_in_fifo", 64'(fifo_q.size()), 64'd2);
        for (int i = 0; i < 4; i++) push(rand_val());
        kick();
        check("t5_done_dropped", 64'(done), 64'd0);
        cycle();
        check("t5_restart_addr", 64'(wr_addr), 64'(BASE));
        run_to_done(30, 0);

        // asynchronous reset mid-job with a write pending
        for (int i = 0; i < 6; i++) push(rand_val());
        kick();
        repeat (3) cycle();
        check("t6_pending", 64'(wr_valid), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("t6_async");
        m_busy = 0; m_done = 0; m_sat = 0; m_valid = 0;
        m_addr = BASE; m_data = '0;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        for (int i = 0; i < 6; i++) push(rand_val());
        kick();
        cycle();
        check("t6_restart_addr", 64'(wr_addr), 64'(BASE));
        run_to_done(30, 0);

        // randomized jobs with random back-pressure and FIFO gaps
        for (int j = 0; j < 6; j++) begin
            kick();
            run_to_done(400, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
